// File: rtl/biu_mem_arbiter.sv
// rtl/biu_mem_arbiter.sv - shares one BIU memory port between fetch and data requesters
// Data side wins conflicts; a starvation counter forces fetch progress and a timeout aborts hung accesses.
package biu_pkg;
    typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} biu_size_t;
endpackage

module biu_mem_arbiter
    import biu_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            im_req,
    input  logic [XLEN-1:0] im_adr,
    output logic            im_ack,
    output logic [XLEN-1:0] im_q,
    output logic            im_err,
    input  logic            dm_req,
    input  logic [XLEN-1:0] dm_adr,
    input  logic [XLEN-1:0] dm_d,
    input  logic            dm_we,
    input  biu_size_t       dm_size,
    output logic            dm_ack,
    output logic [XLEN-1:0] dm_q,
    output logic            dm_err,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_adr,
    output logic [XLEN-1:0] mem_d,
    output logic            mem_we,
    output biu_size_t       mem_size,
    input  logic            mem_ack,
    input  logic            mem_err,
    input  logic [XLEN-1:0] mem_q,
    output logic            mem_gnt_dm
);

    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [SW-1:0]   r_starve_cnt;
    logic [TW-1:0]   r_tmo_cnt;
    logic            r_mem_req;
    logic [XLEN-1:0] r_mem_adr;
    logic [XLEN-1:0] r_mem_d;
    logic            r_mem_we;
    biu_size_t       r_mem_size;
    logic            r_gnt_dm;
    logic [XLEN-1:0] r_im_q;
    logic            r_im_err;
    logic [XLEN-1:0] r_dm_q;
    logic            r_dm_err;
    logic            w_grant;
    logic            w_grant_dm;
    logic            w_done;
    logic            w_tmo;
    logic            w_tmo_hit;

    assign w_tmo_hit = (TIMEOUT != 0) && (r_tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_grant_dm  = 1'b0;
        w_done      = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            IDLE: begin
                if (dm_req || im_req) begin
                    w_grant     = 1'b1;
                    w_grant_dm  = dm_req && (!im_req || (r_starve_cnt < STARVE_MAX));
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                // A real completion in the expiry cycle takes precedence over the abort.
                if (mem_ack || mem_err) begin
                    w_done      = 1'b1;
                    w_state_nxt = RESP;
                end else if (w_tmo_hit) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_starve_cnt <= '0;
            r_tmo_cnt    <= '0;
            r_mem_req    <= 1'b0;
            r_mem_adr    <= '0;
            r_mem_d      <= '0;
            r_mem_we     <= 1'b0;
            r_mem_size   <= WORD;
            r_gnt_dm     <= 1'b0;
            r_im_q       <= '0;
            r_im_err     <= 1'b0;
            r_dm_q       <= '0;
            r_dm_err     <= 1'b0;
        end else begin
            if (w_grant) begin
                r_gnt_dm  <= w_grant_dm;
                r_mem_req <= 1'b1;
                r_tmo_cnt <= '0;
                if (w_grant_dm) begin
                    r_mem_adr    <= dm_adr;
                    r_mem_d      <= dm_d;
                    r_mem_we     <= dm_we;
                    r_mem_size   <= dm_size;
                    r_starve_cnt <= im_req ? r_starve_cnt + SW'(1) : '0;
                end else begin
                    r_mem_adr    <= im_adr;
                    r_mem_d      <= '0;
                    r_mem_we     <= 1'b0;
                    r_mem_size   <= WORD;
                    r_starve_cnt <= '0;
                end
            end
            if (w_done || w_tmo) begin
                r_mem_req <= 1'b0;
                if (r_gnt_dm) begin
                    r_dm_q   <= w_done ? mem_q : '0;
                    r_dm_err <= w_done ? mem_err : 1'b1;
                end else begin
                    r_im_q   <= w_done ? mem_q : '0;
                    r_im_err <= w_done ? mem_err : 1'b1;
                end
            end else if (r_state == BUSY) begin
                r_tmo_cnt <= r_tmo_cnt + TW'(1);
            end
        end
    end

    assign mem_req    = r_mem_req;
    assign mem_adr    = r_mem_adr;
    assign mem_d      = r_mem_d;
    assign mem_we     = r_mem_we;
    assign mem_size   = r_mem_size;
    assign mem_gnt_dm = r_gnt_dm;
    assign im_ack     = (r_state == RESP) && !r_gnt_dm;
    assign dm_ack     = (r_state == RESP) && r_gnt_dm;
    assign im_q       = r_im_q;
    assign im_err     = r_im_err;
    assign dm_q       = r_dm_q;
    assign dm_err     = r_dm_err;

endmodule

// File: tb/tb_biu_mem_arbiter.sv
// tb/tb_biu_mem_arbiter.sv - directed self-checking bench for biu_mem_arbiter
module tb_biu_mem_arbiter;
    import biu_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        im_req;
    logic [31:0] im_adr;
    logic        im_ack;
    logic [31:0] im_q;
    logic        im_err;
    logic        dm_req;
    logic [31:0] dm_adr;
    logic [31:0] dm_d;
    logic        dm_we;
    biu_size_t   dm_size;
    logic        dm_ack;
    logic [31:0] dm_q;
    logic        dm_err;
    logic        mem_req;
    logic [31:0] mem_adr;
    logic [31:0] mem_d;
    logic        mem_we;
    biu_size_t   mem_size;
    logic        mem_ack;
    logic        mem_err;
    logic [31:0] mem_q;
    logic        mem_gnt_dm;

    int n_assert = 0;
    int n_fail   = 0;

    biu_mem_arbiter #(.XLEN(32), .STARVE_LIMIT(4), .TIMEOUT(8)) dut (
        .clk(clk), .rstn(rstn),
        .im_req(im_req), .im_adr(im_adr), .im_ack(im_ack), .im_q(im_q), .im_err(im_err),
        .dm_req(dm_req), .dm_adr(dm_adr), .dm_d(dm_d), .dm_we(dm_we), .dm_size(dm_size),
        .dm_ack(dm_ack), .dm_q(dm_q), .dm_err(dm_err),
        .mem_req(mem_req), .mem_adr(mem_adr), .mem_d(mem_d), .mem_we(mem_we),
        .mem_size(mem_size), .mem_ack(mem_ack), .mem_err(mem_err), .mem_q(mem_q),
        .mem_gnt_dm(mem_gnt_dm)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        int cnt;
        logic exp_dm;

        rstn = 1'b0; im_req = 1'b0; im_adr = '0; dm_req = 1'b0; dm_adr = '0; dm_d = '0;
        dm_we = 1'b0; dm_size = WORD; mem_ack = 1'b0; mem_err = 1'b0; mem_q = '0;
        tick(); tick();
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_size", {30'd0, mem_size}, {30'd0, WORD});
        chk("rst_acks", {30'd0, im_ack, dm_ack}, 32'd0);
        chk("rst_gnt", {31'd0, mem_gnt_dm}, 32'd0);
        chk("rst_dm_q", dm_q, 32'd0);
        rstn = 1'b1;
        tick();

        // Data write, memory acks in the second mem_req cycle.
        dm_req = 1'b1; dm_adr = 32'h100; dm_we = 1'b1; dm_d = 32'hDEADBEEF; dm_size = WORD;
        tick();
        chk("w_req1", {31'd0, mem_req}, 32'd1);
        chk("w_adr1", mem_adr, 32'h100);
        chk("w_we1", {31'd0, mem_we}, 32'd1);
        chk("w_d1", mem_d, 32'hDEADBEEF);
        chk("w_gnt", {31'd0, mem_gnt_dm}, 32'd1);
        chk("w_acks1", {30'd0, im_ack, dm_ack}, 32'd0);
        tick();
        chk("w_req2", {31'd0, mem_req}, 32'd1);
        chk("w_adr2", mem_adr, 32'h100);
        chk("w_we2", {31'd0, mem_we}, 32'd1);
        chk("w_acks2", {30'd0, im_ack, dm_ack}, 32'd0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0; dm_req = 1'b0;
        chk("w_resp_acks", {30'd0, im_ack, dm_ack}, 32'd1);
        chk("w_resp_req", {31'd0, mem_req}, 32'd0);
        chk("w_resp_err", {31'd0, dm_err}, 32'd0);
        tick();
        chk("w_after_acks", {30'd0, im_ack, dm_ack}, 32'd0);

        // Continuous conflict, zero-wait memory: D,D,D,D,I repeating.
        im_req = 1'b1; im_adr = 32'h300; dm_req = 1'b1; dm_adr = 32'h400; dm_we = 1'b0;
        mem_ack = 1'b1;
        for (int k = 0; k < 10; k++) begin
            exp_dm = (k % 5) != 4;
            mem_q = 32'h1000 + k;
            tick();
            chk($sformatf("arb_gnt%0d", k), {31'd0, mem_gnt_dm}, {31'd0, exp_dm});
            chk($sformatf("arb_adr%0d", k), mem_adr, exp_dm ? 32'h400 : 32'h300);
            tick();
            chk($sformatf("arb_ack%0d", k), {30'd0, im_ack, dm_ack}, exp_dm ? 32'd1 : 32'd2);
            if (!exp_dm) chk($sformatf("arb_imq%0d", k), im_q, 32'h1000 + k);
            else         chk($sformatf("arb_dmq%0d", k), dm_q, 32'h1000 + k);
            tick();
        end
        im_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;
        tick();

        // Lone fetch: write-enable and size from the data side must not leak.
        im_req = 1'b1; im_adr = 32'h200; dm_we = 1'b1; dm_size = BYTE;
        tick();
        chk("f_we", {31'd0, mem_we}, 32'd0);
        chk("f_size", {30'd0, mem_size}, {30'd0, WORD});
        chk("f_adr", mem_adr, 32'h200);
        chk("f_gnt", {31'd0, mem_gnt_dm}, 32'd0);
        mem_ack = 1'b1; mem_q = 32'h13;
        tick();
        mem_ack = 1'b0; im_req = 1'b0;
        chk("f_acks", {30'd0, im_ack, dm_ack}, 32'd2);
        chk("f_q", im_q, 32'h13);
        chk("f_err", {31'd0, im_err}, 32'd0);
        tick();

        // mem_err alone completes a data read.
        dm_req = 1'b1; dm_adr = 32'h180; dm_we = 1'b0; dm_size = WORD;
        tick();
        mem_err = 1'b1; mem_q = 32'hBAD0BAD0;
        tick();
        mem_err = 1'b0; dm_req = 1'b0;
        chk("e_acks", {30'd0, im_ack, dm_ack}, 32'd1);
        chk("e_err", {31'd0, dm_err}, 32'd1);
        chk("e_q", dm_q, 32'hBAD0BAD0);
        tick();
        chk("e_idle_acks", {30'd0, im_ack, dm_ack}, 32'd0);
        chk("e_idle_req", {31'd0, mem_req}, 32'd0);
        chk("e_err_hold", {31'd0, dm_err}, 32'd1);

        // Unresponsive memory: timeout after 8 BUSY cycles.
        dm_req = 1'b1; dm_adr = 32'h1F0;
        tick();
        cnt = 0;
        while (mem_req && cnt < 20) begin
            if (dm_ack) chk("t_early_ack", {31'd0, dm_ack}, 32'd0);
            cnt++;
            tick();
        end
        dm_req = 1'b0;
        chk("t_busy_cycles", cnt, 32'd8);
        chk("t_acks", {30'd0, im_ack, dm_ack}, 32'd1);
        chk("t_err", {31'd0, dm_err}, 32'd1);
        chk("t_q", dm_q, 32'd0);
        tick(); tick(); tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("t_late_acks", {30'd0, im_ack, dm_ack}, 32'd0);
        chk("t_late_req", {31'd0, mem_req}, 32'd0);
        tick();
        chk("t_late_acks2", {30'd0, im_ack, dm_ack}, 32'd0);

        // Reset asserted mid-transaction.
        im_req = 1'b1; im_adr = 32'h240; dm_req = 1'b1; dm_adr = 32'h440;
        tick();
        chk("r_busy_req", {31'd0, mem_req}, 32'd1);
        chk("r_busy_gnt", {31'd0, mem_gnt_dm}, 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("r_async_req", {31'd0, mem_req}, 32'd0);
        chk("r_async_acks", {30'd0, im_ack, dm_ack}, 32'd0);
        dm_req = 1'b0; mem_ack = 1'b1;
        tick();
        chk("r_hold_acks", {30'd0, im_ack, dm_ack}, 32'd0);
        rstn = 1'b1; mem_ack = 1'b0;
        chk("r_starve", {29'd0, dut.r_starve_cnt}, 32'd0);
        tick();
        chk("r_new_gnt", {31'd0, mem_gnt_dm}, 32'd0);
        chk("r_new_adr", mem_adr, 32'h240);
        chk("r_new_req", {31'd0, mem_req}, 32'd1);
        mem_ack = 1'b1; mem_q = 32'h55;
        tick();
        mem_ack = 1'b0; im_req = 1'b0;
        chk("r_new_acks", {30'd0, im_ack, dm_ack}, 32'd2);
        chk("r_new_q", im_q, 32'h55);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
